rx_symbol_align: RTL and testbench

Serial-to-parallel front end for the 8b/10b receive path. Shifts in the one-bit-per-clock line stream, hunts for the K28.5 comma, and locks symbol alignment after a run of aligned commas. Once locked, it delivers framed 10-bit symbols to the 8b/10b decoder. The decoder returns a code-error flag, which this block uses to detect loss of alignment and fall back to hunting.

---
 rtl/rx_symbol_align.sv | 159 +++++++++++++++
 tb/tb_rx_symbol_align.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_symbol_align.sv
// rx_symbol_align
// 8b/10b receive front end: shifts in the serial line, hunts for the K28.5
// comma, locks symbol alignment after a run of aligned commas and then
// delivers framed 10-bit symbols. Decoder code errors are used to detect a
// lost alignment and return to hunting.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// HUNT   | no alignment; any comma seen in sr sets the phase
// CHECK  | phase set, counting consecutive aligned commas toward lock
// LOCKED | aligned; one symbol emitted per boundary, errors tracked
module rx_symbol_align #(
  parameter logic [9:0] COMMA_N    = 10'b0011111010,
  parameter logic [9:0] COMMA_P    = 10'b1100000101,
  parameter int         LOCK_COUNT = 3,
  parameter int         LOSS_COUNT = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetN,
  input  logic       Sin,
  input  logic       codeErr,
  output logic [9:0] symOut,
  output logic       symValid,
  output logic       isComma,
  output logic       locked,
  output logic       alignErr
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

  state_t     state;
  logic [9:0] sr;
  logic [3:0] p;
  logic [3:0] cc;
  logic [3:0] ec;

  logic       match;
  logic       boundary;
  logic       relock;
  logic       loss;
  logic [3:0] cc_inc;
  logic [3:0] ec_inc;

  assign match    = (sr == COMMA_N) || (sr == COMMA_P);
  assign boundary = (p == 4'd0);
  assign cc_inc   = cc + 4'd1;
  assign ec_inc   = ec + 4'd1;
  // Any comma that sets a new phase: the first one in HUNT, or one that
  // lands off the current boundary while checking or locked.
  assign relock   = match && ((state == HUNT) || !boundary);
  // Loss of lock outranks every other event in the same cycle.
  assign loss     = symValid && codeErr && (ec_inc == LOSS_C);

  // Serial line shift register, bit 9 is the oldest bit.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      sr <= '0;
    end else begin
      sr <= {sr[8:0], Sin};
    end
  end

  // Phase counter: restarts at 1 on a phase-setting comma, otherwise 0..9.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      p <= '0;
    end else if (relock) begin
      p <= 4'd1;
    end else if (p == 4'd9) begin
      p <= '0;
    end else begin
      p <= p + 4'd1;
    end
  end

  // Alignment FSM with registered outputs and comma/error counters.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      state    <= HUNT;
      cc       <= '0;
      ec       <= '0;
      symOut   <= '0;
      symValid <= 1'b0;
      isComma  <= 1'b0;
      locked   <= 1'b0;
      alignErr <= 1'b0;
    end else begin
      symValid <= 1'b0;
      alignErr <= 1'b0;

      if (symValid) begin
        if (codeErr) begin
          ec <= ec_inc;
        end else begin
          ec <= '0;
        end
      end

      if (loss) begin
        state  <= HUNT;
        locked <= 1'b0;
        ec     <= '0;
        cc     <= '0;
      end else begin
        case (state)
          HUNT: begin
            if (match) begin
              cc    <= 4'd1;
              state <= CHECK;
            end
          end
          CHECK: begin
            if (boundary) begin
              if (match) begin
                cc <= cc_inc;
                if (cc_inc == LOCK_C) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  ec       <= '0;
                  symOut   <= sr;
                  symValid <= 1'b1;
                  isComma  <= 1'b1;
                end
              end else begin
                state <= HUNT;
                cc    <= '0;
              end
            end else if (match) begin
              cc <= 4'd1;
            end
          end
          LOCKED: begin
            if (boundary) begin
              symOut   <= sr;
              symValid <= 1'b1;
              isComma  <= match;
            end else if (match) begin
              alignErr <= 1'b1;
              locked   <= 1'b0;
              state    <= CHECK;
              cc       <= 4'd1;
            end
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_symbol_align.sv
// Directed-sequence bench for rx_symbol_align with randomized filler data and
// a behavioural model that tracks alignment as an anchor edge number.
module tb_rx_symbol_align;

  localparam logic [9:0] CN     = 10'b0011111010;
  localparam logic [9:0] CP     = 10'b1100000101;
  localparam logic [9:0] D215   = 10'b1010101010;
  localparam int         LOCK_N = 3;
  localparam int         LOSS_N = 4;

  logic       CLOCK_50 = 1'b0;
  logic       resetN   = 1'b1;
  logic       Sin      = 1'b0;
  logic       codeErr  = 1'b0;
  logic [9:0] symOut;
  logic       symValid;
  logic       isComma;
  logic       locked;
  logic       alignErr;

  rx_symbol_align #(
    .COMMA_N   (CN),
    .COMMA_P   (CP),
    .LOCK_COUNT(LOCK_N),
    .LOSS_COUNT(LOSS_N)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetN  (resetN),
    .Sin     (Sin),
    .codeErr (codeErr),
    .symOut  (symOut),
    .symValid(symValid),
    .isComma (isComma),
    .locked  (locked),
    .alignErr(alignErr)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  // Reference model state: mode 0 hunting, 1 checking, 2 locked.
  logic [9:0] m_win;
  int         m_mode, m_anchor, m_t, m_cnt, m_errs;
  logic [9:0] m_sym;
  logic       m_valid, m_comma, m_locked, m_aerr;

  logic       comma_rd;
  int         comma_pos;
  logic [3:0] hist;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_win = '0; m_mode = 0; m_anchor = 0; m_cnt = 0; m_errs = 0;
    m_sym = '0; m_valid = 1'b0; m_comma = 1'b0; m_locked = 1'b0; m_aerr = 1'b0;
  endtask

  // Applies one clock edge to the model; b and e are the sampled inputs.
  task automatic model_update(input logic b, input logic e);
    logic mt, bnd, pv, lost;
    m_t++;
    if (resetN) begin
      mt   = (m_win == CN) || (m_win == CP);
      bnd  = ((m_t - m_anchor) % 10) == 0;
      pv   = m_valid;
      m_valid = 1'b0;
      m_aerr  = 1'b0;
      lost = 1'b0;
      if (pv) begin
        if (e) begin
          m_errs++;
          if (m_errs == LOSS_N) begin
            m_mode = 0; m_locked = 1'b0; m_errs = 0; m_cnt = 0; lost = 1'b1;
          end
        end else begin
          m_errs = 0;
        end
      end
      if (!lost) begin
        if (m_mode == 0) begin
          if (mt) begin m_anchor = m_t; m_cnt = 1; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (bnd) begin
            if (mt) begin
              m_cnt++;
              if (m_cnt == LOCK_N) begin
                m_mode = 2; m_locked = 1'b1; m_errs = 0;
                m_sym = m_win; m_valid = 1'b1; m_comma = 1'b1;
              end
            end else begin
              m_mode = 0; m_cnt = 0;
            end
          end else if (mt) begin
            m_anchor = m_t; m_cnt = 1;
          end
        end else begin
          if (bnd) begin
            m_sym = m_win; m_valid = 1'b1; m_comma = mt;
          end else if (mt) begin
            m_aerr = 1'b1; m_locked = 1'b0; m_mode = 1; m_anchor = m_t; m_cnt = 1;
          end
        end
      end
      m_win = {m_win[8:0], b};
    end
  endtask

  function automatic int phase();
    return (m_t - m_anchor + 1) % 10;
  endfunction

  task automatic step(input logic b, input logic e);
    Sin     = b;
    codeErr = e;
    hist    = {hist[2:0], b};
    @(posedge CLOCK_50);
    model_update(b, e);
    @(negedge CLOCK_50);
    chk("cycle", {symOut, symValid, isComma, locked, alignErr},
        {m_sym, m_valid, m_comma, m_locked, m_aerr});
  endtask

  // Random data that never holds five equal bits in a row, so it cannot
  // contain a comma on its own.
  task automatic send_rand(input int n);
    logic r;
    for (int i = 0; i < n; i++) begin
      r = 1'($urandom_range(0, 1));
      if (hist == 4'hF) r = 1'b0;
      else if (hist == 4'h0) r = 1'b1;
      step(r, 1'b0);
    end
  endtask

  task automatic comma_step(input logic e);
    logic [9:0] v;
    logic       b;
    v = comma_rd ? CP : CN;
    b = v[9 - comma_pos];
    comma_pos++;
    if (comma_pos == 10) begin
      comma_pos = 0;
      comma_rd  = ~comma_rd;
    end
    step(b, e);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n * 10; i++) comma_step(1'b0);
  endtask

  task automatic finish_comma();
    for (int i = 0; i < 10 && comma_pos != 0; i++) comma_step(1'b0);
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) step(w[i], 1'b0);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    model_reset();
    #1;
    chk("reset_now", {symOut, symValid, isComma, locked, alignErr}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    resetN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_land, t_lock, last_t, k, aerr_cnt, idx, cur;
    logic seen_unlock, consumed, e;
    logic [7:0] pat;
    logic [9:0] dw;

    model_reset();
    m_t = 0; comma_rd = 1'b0; comma_pos = 0; hist = 4'h0;

    // Reset held with a toggling line.
    #1 resetN = 1'b0;
    for (int i = 0; i < 20; i++) step(~Sin, 1'b0);
    chk("reset_hold_outputs", {symOut, symValid, isComma, locked, alignErr}, 32'd0);
    resetN = 1'b1;
    send_rand(40);
    chk("idle_hunt_outputs", {symOut, symValid, isComma, locked, alignErr}, 32'd0);

    // Lock from a 3-bit offset on a continuous comma stream.
    send_rand(3);
    comma_rd = 1'b0; comma_pos = 0;
    send_commas(1);
    t_land = m_t;
    t_lock = -1;
    for (int i = 0; i < 60 && t_lock < 0; i++) begin
      comma_step(1'b0);
      if (locked === 1'b1) t_lock = m_t;
    end
    chk("lock_latency", t_lock - t_land, 21);
    chk("lock_sym_valid", symValid, 1);
    chk("lock_sym", symOut, CN);
    chk("lock_is_comma", isComma, 1);

    last_t = m_t; k = 0;
    for (int i = 0; i < 40; i++) begin
      comma_step(1'b0);
      if (symValid === 1'b1) begin
        chk("cadence", m_t - last_t, 10);
        chk("pulse_sym", symOut, (k % 2 == 0) ? CP : CN);
        chk("pulse_comma", isComma, 1);
        last_t = m_t;
        k++;
      end
    end
    chk("pulse_count", k, 4);

    // Data symbol after lock.
    finish_comma();
    send_word(D215);
    chk("d215_not_yet", symValid, 0);
    comma_step(1'b0);
    chk("d215_valid", symValid, 1);
    chk("d215_sym", symOut, 10'h2AA);
    chk("d215_comma", isComma, 0);
    finish_comma();

    // CHECK abort: two commas then a data symbol.
    do_reset();
    send_rand(5 + $urandom_range(0, 7));
    comma_rd = 1'b0; comma_pos = 0;
    send_commas(2);
    send_word(D215);
    send_rand(7);
    chk("abort_not_locked", locked, 0);
    send_commas(3);
    comma_step(1'b0);
    chk("relock_after_abort", locked, 1);

    // Misaligned comma while locked.
    finish_comma();
    send_commas(1);
    send_rand(3);
    aerr_cnt = 0; seen_unlock = 1'b0;
    for (int i = 0; i < 31; i++) begin
      comma_step(1'b0);
      if (alignErr === 1'b1) aerr_cnt++;
      if (locked === 1'b0) seen_unlock = 1'b1;
    end
    chk("align_err_pulses", aerr_cnt, 1);
    chk("align_unlock_seen", seen_unlock, 1);
    chk("relock_new_phase", locked, 1);

    // Loss of lock: error pattern on successive pulses, random elsewhere.
    finish_comma();
    pat = 8'b1110_1111;
    dw  = D215;
    idx = 0;
    for (int i = 0; i < 150 && idx < 8; i++) begin
      consumed = 1'b0;
      cur = idx;
      if (m_valid) begin
        e = pat[7 - idx];
        consumed = 1'b1;
        idx++;
      end else begin
        e = 1'($urandom_range(0, 1));
      end
      step(dw[9 - (i % 10)], e);
      if (consumed) chk("loss_locked", locked, (cur == 7) ? 0 : 1);
    end
    chk("loss_pattern_done", idx, 8);

    // Asynchronous reset in the middle of a symbol while locked.
    send_rand(5);
    comma_rd = 1'b0; comma_pos = 0;
    send_commas(3);
    comma_step(1'b0);
    chk("mid_reset_locked", locked, 1);
    for (int i = 0; i < 20 && phase() != 5; i++) comma_step(1'b0);
    chk("mid_reset_phase", phase(), 5);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", {symOut, symValid, isComma, locked, alignErr}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    resetN = 1'b1;
    send_rand(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
